lspc_timer_ng: RTL and testbench
================================

Name: lspc_timer_ng

Overview:
Parametrised successor to the LSPC raster timer. It is a down-counting programmable interval timer with a configurable counter width and a tick prescaler. It supports three reload sources: 68k write, vblank start, and auto-reload on underflow. It adds a sticky IRQ with acknowledge and the PAL border stop window. It sits in the LSPC video block, clocked from the 6 MHz pixel domain, and drives the 68k timer interrupt.

Parameters:
WIDTH, 32, counter/reload width; legal 17..32; high register holds bits WIDTH-1:16.
PRESCALE, 1, enabled clocks per counter decrement; legal 1..16.
RELOAD_DLY, 2, cycles from WR_TIMER_LOW strobe to the mode-0 reload; legal 1..4.

Ports:
LSPC_6M  in  1  clock, all logic on rising edge
nRESETP  in  1  asynchronous active-low reset
M68K_DATA  in  16  write data
WR_TIMER_HIGH  in  1  1-cycle strobe, sync to LSPC_6M; loads reload bits WIDTH-1:16 from M68K_DATA[WIDTH-17:0]
WR_TIMER_LOW  in  1  1-cycle strobe; loads reload bits 15:0
TIMER_MODE  in  3  bit0 reload on low write; bit1 reload at vblank; bit2 auto-reload on underflow
VBLANK_START  in  1  1-cycle pulse at first vblank line
TIMER_IRQ_EN  in  1  IRQ enable
IRQ_ACK  in  1  1-cycle acknowledge, clears pending
TIMER_STOP  in  1  enable the PAL border stop window
VMODE  in  1  1 = PAL
RASTERC  in  9  current raster line
TIMER_CO  out  1  1-cycle underflow pulse
TIMER_IRQ  out  1  level, pending interrupt

Behaviour:
- Reset (async, nRESETP=0): reload register R=0, counter C=0, prescaler P=0, armed=0, delay line cleared. TIMER_CO=0, TIMER_IRQ=0.
- armed=0 holds C and suppresses TIMER_CO. The first reload event of any source sets armed=1 permanently, until the next reset.
- Register writes take effect on the clock edge of the strobe. A high write never reloads C.
- Mode-0 reload: when TIMER_MODE[0]=1, C<=R occurs exactly RELOAD_DLY cycles after the WR_TIMER_LOW strobe, using R as it stands at reload time.
  - A new low write during the delay restarts the delay; only one reload results.
  - Strobe with TIMER_MODE[0]=0: no reload.
- Mode-1 reload: when TIMER_MODE[1]=1, C<=R one cycle after VBLANK_START (registered).
- Stop window: stop = TIMER_STOP & VMODE & (RASTERC[8]=0) & (RASTERC[5:4]=00). It is registered, giving 1-cycle latency. tick_en = armed & ~stop_q.
- Prescaler: when tick_en=1, P increments. A tick occurs when P=PRESCALE-1; P then wraps to 0. Any reload clears P. With PRESCALE=1, every enabled cycle is a tick.
- On a tick:
  - C!=0: C<=C-1.
  - C==0: underflow. TIMER_CO=1 on the next cycle. C<=R if TIMER_MODE[2]=1, else C<=all-ones (free-run wrap).
  - The period is therefore R+1 ticks.
- Simultaneous reload and tick in the same cycle: the reload wins and the decrement is discarded. If that tick was an underflow, TIMER_CO still pulses.
- Simultaneous mode-0 and mode-1 reloads: a single reload.
- IRQ:
  - Underflow with TIMER_IRQ_EN=1 sets pending.
  - IRQ_ACK clears pending. Set and ACK in the same cycle: set wins.
  - TIMER_IRQ_EN=0 clears pending and blocks setting it.
  - TIMER_IRQ = pending, registered.
- R=0 with mode 2: underflow on every tick, and TIMER_CO is high continuously at PRESCALE=1.

Optional Feature:
TIMER_READBACK_EN. When defined:
- Adds output port TIMER_COUNT [WIDTH-1:0], equal to registered C.
- Adds input RD_SNAP; a 1-cycle strobe latches C into an internal snapshot.
- TIMER_COUNT shows the snapshot value while a new RD_SNAP is absent, so the 68k can read a coherent value across two 16-bit reads.
When undefined: neither port exists and no snapshot logic is generated.

Test Plan:
- Reset, then no writes for 1000 cycles -> TIMER_CO and TIMER_IRQ stay 0, and C stays 0 (armed=0).
- Mode=001 and mode=100, R=0x00000004, PRESCALE=1, IRQ_EN=1, write low at cycle t -> reload at t+2. TIMER_CO pulses at t+7, t+12, t+17. TIMER_IRQ rises at t+8 and holds until IRQ_ACK.
- Mode=010, R=9, VBLANK_START pulse -> C=9 one cycle later. A second VBLANK_START mid-count restarts C at 9 and no TIMER_CO occurs in between.
- PAL, TIMER_STOP=1, RASTERC=0x00F -> C frozen. RASTERC=0x010 -> decrement resumes after 1 cycle. VMODE=0 -> no freeze.
- Mode=000 after arming, R=0 -> after underflow C=0xFFFFFFFF and decrements. Reload asserted in the same cycle as an underflow tick -> C=R, TIMER_CO pulses once.
- PRESCALE=3 build, R=1 -> TIMER_CO every 6 enabled cycles. IRQ_ACK in the same cycle as an underflow -> TIMER_IRQ stays 1.

Source files
------------

// File: rtl/lspc_timer_ng.sv
// lspc_timer_ng: parametrised LSPC raster interval timer.
// Down-counter with prescaler and three reload sources (68k low write, vblank,
// auto-reload on underflow), a sticky acknowledged IRQ and the PAL border
// stop window.
// Optional snapshot readback port is built when TIMER_READBACK_EN is defined.
module lspc_timer_ng #(
  parameter int WIDTH      = 32,  // 17..32
  parameter int PRESCALE   = 1,   // 1..16
  parameter int RELOAD_DLY = 2    // 1..4
) (
  input  logic             LSPC_6M,
  input  logic             nRESETP,
  input  logic [15:0]      M68K_DATA,
  input  logic             WR_TIMER_HIGH,
  input  logic             WR_TIMER_LOW,
  input  logic [2:0]       TIMER_MODE,
  input  logic             VBLANK_START,
  input  logic             TIMER_IRQ_EN,
  input  logic             IRQ_ACK,
  input  logic             TIMER_STOP,
  input  logic             VMODE,
  input  logic [8:0]       RASTERC,
`ifdef TIMER_READBACK_EN
  input  logic             RD_SNAP,
  output logic [WIDTH-1:0] TIMER_COUNT,
`endif
  output logic             TIMER_CO,
  output logic             TIMER_IRQ
);

  localparam int         HI_W     = WIDTH - 16;
  localparam logic [3:0] PRE_LAST = 4'(PRESCALE - 1);
  localparam logic [2:0] DLY_INIT = 3'(RELOAD_DLY);

  logic [WIDTH-1:0] r_reload;
  logic [WIDTH-1:0] r_count;
  logic [3:0]       r_pre;
  logic             r_armed;
  logic [2:0]       r_dly;
  logic             r_vbl_q;
  logic             r_stop_q;
  logic             r_co;
  logic             r_pending;
  logic             r_irq;

  logic             w_reload0;
  logic             w_reload;
  logic             w_stop;
  logic             w_tick_en;
  logic             w_tick;
  logic             w_underflow;
  logic             w_unused_raster;

  // Only bit 8 and bits 5:4 of the raster line select the border window.
  assign w_unused_raster = ^{RASTERC[7:6], RASTERC[3:0]};

  // A new low write while a delayed reload is pending cancels that reload;
  // the fresh strobe restarts the delay so only one reload ever lands.
  assign w_reload0   = (r_dly == 3'd1) & ~WR_TIMER_LOW;
  assign w_reload    = w_reload0 | r_vbl_q;
  assign w_stop      = TIMER_STOP & VMODE & ~RASTERC[8] & (RASTERC[5:4] == 2'b00);
  assign w_tick_en   = r_armed & ~r_stop_q;
  assign w_tick      = w_tick_en & (r_pre == PRE_LAST);
  assign w_underflow = w_tick & (r_count == '0);

  // Reload register: high and low halves written independently by the 68k.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_reload <= '0;
    end else begin
      if (WR_TIMER_HIGH) r_reload[WIDTH-1:16] <= M68K_DATA[HI_W-1:0];
      if (WR_TIMER_LOW)  r_reload[15:0]       <= M68K_DATA;
    end
  end

  // Mode-0 delay line: counts down from RELOAD_DLY after each low write.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_dly <= 3'd0;
    end else if (WR_TIMER_LOW) begin
      r_dly <= TIMER_MODE[0] ? DLY_INIT : 3'd0;
    end else if (r_dly != 3'd0) begin
      r_dly <= r_dly - 3'd1;
    end
  end

  // Registered vblank reload request and border stop window.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_vbl_q  <= 1'b0;
      r_stop_q <= 1'b0;
    end else begin
      r_vbl_q  <= VBLANK_START & TIMER_MODE[1];
      r_stop_q <= w_stop;
    end
  end

  // Arming: the first reload of any source starts the timer for good.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_armed <= 1'b0;
    end else if (w_reload) begin
      r_armed <= 1'b1;
    end
  end

  // Prescaler: a tick every PRESCALE enabled cycles, restarted by any reload.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_pre <= 4'd0;
    end else if (w_reload) begin
      r_pre <= 4'd0;
    end else if (w_tick_en) begin
      r_pre <= (r_pre == PRE_LAST) ? 4'd0 : r_pre + 4'd1;
    end
  end

  // Counter: reload beats tick; underflow reloads (mode 2) or wraps to all-ones.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_count <= '0;
    end else if (w_reload) begin
      r_count <= r_reload;
    end else if (w_tick) begin
      if (w_underflow) begin
        r_count <= TIMER_MODE[2] ? r_reload : '1;
      end else begin
        r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  // Carry-out pulse, one cycle after the underflowing tick.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_co <= 1'b0;
    end else begin
      r_co <= w_underflow;
    end
  end

  // Sticky interrupt: enable low clears, underflow sets, ack clears (set wins).
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (!TIMER_IRQ_EN)    r_pending <= 1'b0;
      else if (w_underflow) r_pending <= 1'b1;
      else if (IRQ_ACK)     r_pending <= 1'b0;
      r_irq <= r_pending;
    end
  end

  assign TIMER_CO  = r_co;
  assign TIMER_IRQ = r_irq;

`ifdef TIMER_READBACK_EN
  logic [WIDTH-1:0] r_snap;

  // Snapshot keeps the count stable across the two 16-bit 68k reads.
  always_ff @(posedge LSPC_6M or negedge nRESETP) begin
    if (!nRESETP) begin
      r_snap <= '0;
    end else if (RD_SNAP) begin
      r_snap <= r_count;
    end
  end

  assign TIMER_COUNT = r_snap;
`endif

endmodule

// File: tb/tb_lspc_timer_ng.sv
// tb_lspc_timer_ng: self-checking bench for lspc_timer_ng.
// Two instances share stimulus: dut (PRESCALE=1) and dut_p3 (PRESCALE=3).
// Expected TIMER_CO cycles are queued when stimulus is driven and checked
// by per-instance monitors.
module tb_lspc_timer_ng;

  logic        clk;
  logic        rst_n;
  logic [15:0] m68k_data;
  logic        wr_high;
  logic        wr_low;
  logic [2:0]  timer_mode;
  logic        vblank_start;
  logic        irq_en;
  logic        irq_ack;
  logic        timer_stop;
  logic        vmode;
  logic [8:0]  rasterc;
  logic        co;
  logic        irq;
  logic        co3;
  logic        irq3;
`ifdef TIMER_READBACK_EN
  logic        rd_snap;
  logic [31:0] count_rb;
  logic [31:0] count_rb3;
`endif

  int          cyc;
  int          n_tests;
  int          n_fail;
  logic        mon_en;
  logic        mon3_en;
  logic [31:0] exp_q[$];
  logic [31:0] exp3_q[$];

  lspc_timer_ng dut (
    .LSPC_6M(clk), .nRESETP(rst_n), .M68K_DATA(m68k_data),
    .WR_TIMER_HIGH(wr_high), .WR_TIMER_LOW(wr_low), .TIMER_MODE(timer_mode),
    .VBLANK_START(vblank_start), .TIMER_IRQ_EN(irq_en), .IRQ_ACK(irq_ack),
    .TIMER_STOP(timer_stop), .VMODE(vmode), .RASTERC(rasterc),
`ifdef TIMER_READBACK_EN
    .RD_SNAP(rd_snap), .TIMER_COUNT(count_rb),
`endif
    .TIMER_CO(co), .TIMER_IRQ(irq)
  );

  lspc_timer_ng #(.PRESCALE(3)) dut_p3 (
    .LSPC_6M(clk), .nRESETP(rst_n), .M68K_DATA(m68k_data),
    .WR_TIMER_HIGH(wr_high), .WR_TIMER_LOW(wr_low), .TIMER_MODE(timer_mode),
    .VBLANK_START(vblank_start), .TIMER_IRQ_EN(irq_en), .IRQ_ACK(irq_ack),
    .TIMER_STOP(timer_stop), .VMODE(vmode), .RASTERC(rasterc),
`ifdef TIMER_READBACK_EN
    .RD_SNAP(rd_snap), .TIMER_COUNT(count_rb3),
`endif
    .TIMER_CO(co3), .TIMER_IRQ(irq3)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        n_tests++;
        void'(exp_q.pop_front());
        if (co !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL co_pulse: cycle %0d TIMER_CO=%b, required 1", cyc, co);
        end
      end else if (co !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL co_spurious: cycle %0d TIMER_CO=%b, required 0", cyc, co);
      end
    end
    if (mon3_en) begin
      if (exp3_q.size() > 0 && exp3_q[0] == cyc) begin
        n_tests++;
        void'(exp3_q.pop_front());
        if (co3 !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL p3_co_pulse: cycle %0d TIMER_CO=%b, required 1", cyc, co3);
        end
      end else if (co3 !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("[TB] FAIL p3_co_spurious: cycle %0d TIMER_CO=%b, required 0", cyc, co3);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic wr_high_t(input logic [15:0] d);
    m68k_data = d;
    wr_high   = 1'b1;
    step();
    wr_high   = 1'b0;
  endtask

  task automatic wr_low_t(input logic [15:0] d);
    m68k_data = d;
    wr_low    = 1'b1;
    step();
    wr_low    = 1'b0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    mon3_en = 1'b0;
    exp_q.delete();
    exp3_q.delete();
    m68k_data = '0; wr_high = 0; wr_low = 0; timer_mode = '0;
    vblank_start = 0; irq_en = 0; irq_ack = 0; timer_stop = 0;
    vmode = 0; rasterc = '0;
`ifdef TIMER_READBACK_EN
    rd_snap = 0;
`endif
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_count(input string name, input logic [31:0] exp);
    n_tests++;
    if (dut.r_count !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: cycle %0d count=%h, required %h", name, cyc, dut.r_count, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (co !== 1'b0 || irq !== 1'b0 || dut.r_count !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: co=%b irq=%b count=%h, required 0 0 0", co, irq, dut.r_count);
    end
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      m68k_data  = 16'($urandom_range(0, 65535));
      wr_high    = 1'($urandom_range(0, 1));
      timer_mode = 3'($urandom_range(0, 7));
      irq_en     = 1'($urandom_range(0, 1));
      irq_ack    = 1'($urandom_range(0, 1));
      timer_stop = 1'($urandom_range(0, 1));
      vmode      = 1'($urandom_range(0, 1));
      rasterc    = 9'($urandom_range(0, 511));
      step();
      n_tests++;
      if (co !== 1'b0 || irq !== 1'b0 || dut.r_count !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL idle_unarmed: cycle %0d co=%b irq=%b count=%h, required 0 0 0",
                 cyc, co, irq, dut.r_count);
      end
    end
  endtask

  task automatic test_mode0_auto();
    int t;
    do_reset();
    irq_en = 1'b1;
    timer_mode = 3'b101;
    wr_high_t(16'h0000);
    wr_low_t(16'h0004);
    t = cyc;
    exp_q.push_back(32'(t + 7));
    exp_q.push_back(32'(t + 12));
    exp_q.push_back(32'(t + 17));
    exp_q.push_back(32'(t + 22));
    mon_en = 1'b1;
    step();
    check_count("mode0_delay", 32'h0);
    step();
    check_count("mode0_reload", 32'h4);
    run_to(t + 7);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_latency: irq=%b, required 0", irq); end
    run_to(t + 8);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_rise: irq=%b, required 1", irq); end
    run_to(t + 18);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_hold: irq=%b, required 1", irq); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_ack: irq=%b, required 0", irq); end
    run_to(t + 22);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_after_ack: irq=%b, required 0", irq); end
    step();
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_reset: irq=%b, required 1", irq); end
    step();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL mode0_queue: %0d left, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_reload_restart();
    int t;
    do_reset();
    timer_mode = 3'b001;
    wr_high_t(16'h0001);
    step();
    check_count("high_no_reload", 32'h0);
    wr_low_t(16'h0007);
    t = cyc;
    wr_low_t(16'h0006);
    step();
    check_count("restart_no_early", 32'h0);
    step();
    check_count("restart_reload", 32'h0001_0006);
    step();
    check_count("restart_dec", 32'h0001_0005);
  endtask

  task automatic test_vblank();
    int v;
    do_reset();
    timer_mode = 3'b010;
    wr_high_t(16'h0000);
    wr_low_t(16'h0009);
    step(); step(); step();
    check_count("low_mode0_off", 32'h0);
    mon_en = 1'b1;
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    v = cyc;
    check_count("vbl_latency", 32'h0);
    step();
    check_count("vbl_reload", 32'h9);
    run_to(v + 4);
    check_count("vbl_count", 32'h6);
    vblank_start = 1'b1;
    step();
    vblank_start = 1'b0;
    check_count("vbl2_latency", 32'h5);
    step();
    check_count("vbl2_reload", 32'h9);
    step();
    check_count("vbl2_dec", 32'h8);
    run_to(v + 14);
    check_count("vbl2_late", 32'h1);
    mon_en = 1'b0;
  endtask

  task automatic test_stop_window();
    int t;
    do_reset();
    timer_stop = 1'b1;
    vmode = 1'b1;
    rasterc = 9'h00F;
    timer_mode = 3'b001;
    wr_high_t(16'h0000);
    wr_low_t(16'd100);
    t = cyc;
    run_to(t + 2);
    check_count("stop_reload", 32'd100);
    run_to(t + 5);
    check_count("stop_frozen", 32'd100);
    rasterc = 9'h010;
    step();
    check_count("stop_exit_lat", 32'd100);
    step();
    check_count("stop_resume", 32'd99);
    step();
    check_count("stop_run", 32'd98);
    rasterc = 9'h00F;
    step();
    check_count("stop_enter_lat", 32'd97);
    step();
    step();
    check_count("stop_refrozen", 32'd97);
    vmode = 1'b0;
    step();
    check_count("ntsc_lat", 32'd97);
    step();
    check_count("ntsc_no_freeze", 32'd96);
  endtask

  task automatic test_freerun();
    int t;
    do_reset();
    timer_mode = 3'b001;
    wr_high_t(16'h0000);
    wr_low_t(16'h0000);
    t = cyc;
    exp_q.push_back(32'(t + 3));
    mon_en = 1'b1;
    run_to(t + 2);
    check_count("free_reload0", 32'h0);
    timer_mode = 3'b000;
    step();
    check_count("free_wrap", 32'hFFFF_FFFF);
    step();
    check_count("free_dec", 32'hFFFF_FFFE);
    step();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL free_queue: %0d left, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    int t;
    do_reset();
    timer_mode = 3'b001;
    wr_high_t(16'h0000);
    wr_low_t(16'h0003);
    t = cyc;
    exp_q.push_back(32'(t + 6));
    exp_q.push_back(32'(t + 12));
    mon_en = 1'b1;
    run_to(t + 3);
    check_count("col_pre", 32'h2);
    wr_low_t(16'h0005);
    check_count("col_dec", 32'h1);
    step();
    check_count("col_zero", 32'h0);
    step();
    check_count("col_reload_wins", 32'h5);
    step();
    check_count("col_after", 32'h4);
    run_to(t + 12);
    check_count("col_freewrap", 32'hFFFF_FFFF);
    step();
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL col_queue: %0d left, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_r0_auto();
    int t;
    do_reset();
    irq_en = 1'b1;
    timer_mode = 3'b101;
    wr_high_t(16'h0000);
    wr_low_t(16'h0000);
    t = cyc;
    run_to(t + 2);
    n_tests++;
    if (co !== 1'b0) begin n_fail++; $display("[TB] FAIL r0_pre: co=%b, required 0", co); end
    for (int i = 3; i <= 10; i++) begin
      step();
      n_tests++;
      if (co !== 1'b1 || dut.r_count !== 32'h0) begin
        n_fail++;
        $display("[TB] FAIL r0_continuous: cycle %0d co=%b count=%h, required 1 0", cyc, co, dut.r_count);
      end
    end
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL r0_irq: irq=%b, required 1", irq); end
  endtask

  task automatic test_irq_enable();
    int t;
    do_reset();
    timer_mode = 3'b101;
    wr_high_t(16'h0000);
    wr_low_t(16'h0002);
    t = cyc;
    exp_q.push_back(32'(t + 5));
    exp_q.push_back(32'(t + 8));
    exp_q.push_back(32'(t + 11));
    exp_q.push_back(32'(t + 14));
    mon_en = 1'b1;
    run_to(t + 10);
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_blocked: irq=%b, required 0", irq); end
    irq_en = 1'b1;
    run_to(t + 12);
    n_tests++;
    if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_enabled: irq=%b, required 1", irq); end
    irq_en = 1'b0;
    step();
    step();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_en_clear: irq=%b, required 0", irq); end
    step();
    n_tests++;
    if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_en_block: irq=%b, required 0", irq); end
    n_tests++;
    if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL irqen_queue: %0d left, required 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_prescale3();
    int t;
    do_reset();
    irq_en = 1'b1;
    timer_mode = 3'b101;
    wr_high_t(16'h0000);
    wr_low_t(16'h0001);
    t = cyc;
    exp3_q.push_back(32'(t + 8));
    exp3_q.push_back(32'(t + 14));
    exp3_q.push_back(32'(t + 20));
    mon3_en = 1'b1;
    run_to(t + 4);
    n_tests++;
    if (dut_p3.r_count !== 32'h1) begin n_fail++; $display("[TB] FAIL p3_hold: count=%h, required 1", dut_p3.r_count); end
    step();
    n_tests++;
    if (dut_p3.r_count !== 32'h0) begin n_fail++; $display("[TB] FAIL p3_tick: count=%h, required 0", dut_p3.r_count); end
    run_to(t + 8);
    n_tests++;
    if (irq3 !== 1'b0) begin n_fail++; $display("[TB] FAIL p3_irq_lat: irq=%b, required 0", irq3); end
    step();
    n_tests++;
    if (irq3 !== 1'b1) begin n_fail++; $display("[TB] FAIL p3_irq_rise: irq=%b, required 1", irq3); end
    run_to(t + 13);
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    n_tests++;
    if (irq3 !== 1'b1) begin n_fail++; $display("[TB] FAIL p3_set_wins: irq=%b, required 1", irq3); end
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
    step();
    n_tests++;
    if (irq3 !== 1'b0) begin n_fail++; $display("[TB] FAIL p3_ack: irq=%b, required 0", irq3); end
    run_to(t + 21);
    n_tests++;
    if (irq3 !== 1'b1) begin n_fail++; $display("[TB] FAIL p3_irq_again: irq=%b, required 1", irq3); end
    step();
    n_tests++;
    if (exp3_q.size() != 0) begin n_fail++; $display("[TB] FAIL p3_queue: %0d left, required 0", exp3_q.size()); end
    mon3_en = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    mon3_en = 1'b0;
    m68k_data = '0; wr_high = 0; wr_low = 0; timer_mode = '0;
    vblank_start = 0; irq_en = 0; irq_ack = 0; timer_stop = 0;
    vmode = 0; rasterc = '0; rst_n = 1'b1;
`ifdef TIMER_READBACK_EN
    rd_snap = 0;
`endif
    step();
    test_reset();
    test_mode0_auto();
    test_reload_restart();
    test_vblank();
    test_stop_window();
    test_freerun();
    test_back_to_back();
    test_r0_auto();
    test_irq_enable();
    test_prescale3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
